// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: E-stage forwarding, load-use stall, branch flush and multi-cycle execute stall.
// Optional performance counters (stall_cnt, flush_cnt) are compiled in when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int MC_LAT = 4,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              PCsrcE,
   input  logic              MemReadE,
   input  logic              McStartE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic [REG_AW-1:0] rdE,
   input  logic [REG_AW-1:0] rdM,
   input  logic [REG_AW-1:0] rdW,
   input  logic [REG_AW-1:0] rs1D,
   input  logic [REG_AW-1:0] rs2D,
   input  logic [REG_AW-1:0] rs1E,
   input  logic [REG_AW-1:0] rs2E,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic              McBusy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam bit               MC_EN   = (MC_LAT > 1);
   localparam logic [CNT_W-1:0] MC_INIT = CNT_W'(MC_LAT - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             lu, mc_go;

   // M-stage result is newer than W-stage, so it wins; x0 is hardwired zero and never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic              wm,
      input logic [REG_AW-1:0] rm,
      input logic              ww,
      input logic [REG_AW-1:0] rw
   );
      if (wm && (rm != '0) && (rm == rs))
         return 2'b10;
      else if (ww && (rw != '0) && (rw == rs))
         return 2'b01;
      return 2'b00;
   endfunction

   assign lu    = MemReadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
   assign mc_go = McStartE && MC_EN;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      McBusy    = 1'b0;
      if (!rst) begin
         ForwardAE = fwd_sel(rs1E, RegWriteM, rdM, RegWriteW, rdW);
         ForwardBE = fwd_sel(rs2E, RegWriteM, rdM, RegWriteW, rdW);
         if (state == BUSY) begin
            // The op occupies E; freeze F/D/E and feed bubbles into M until the count expires.
            McBusy = 1'b1;
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            cnt_nx = cnt - 1'b1;
            if (cnt == CNT_W'(1))
               state_nx = IDLE;
         end else begin
            if (mc_go) begin
               state_nx = BUSY;
               cnt_nx   = MC_INIT;
            end
            // Branch squashes the stalled D instruction anyway, so it beats load-use.
            if (PCsrcE) begin
               FlushD = 1'b1;
               FlushE = 1'b1;
            end else if (mc_go) begin
               StallF = 1'b1;
               StallD = 1'b1;
               StallE = 1'b1;
               FlushM = 1'b1;
            end else if (lu) begin
               StallF = 1'b1;
               StallD = 1'b1;
               FlushE = 1'b1;
            end
         end
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (StallF)
            stall_cnt <= stall_cnt + 32'd1;
         if (FlushD)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int MC_LAT = 4;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              PCsrcE, MemReadE, McStartE, RegWriteM, RegWriteW;
   logic [REG_AW-1:0] rdE, rdM, rdW, rs1D, rs2D, rs1E, rs2E;
   logic [1:0]        ForwardAE, ForwardBE;
   logic              StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
`ifdef HAZARD_PERF_EN
   logic [31:0]       stall_cnt, flush_cnt;
`endif

   int tests = 0;
   int fails = 0;

   logic [10:0] got, exp_v;
   assign got = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy};

   hazard_ctrl #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .PCsrcE(PCsrcE), .MemReadE(MemReadE), .McStartE(McStartE),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .rdE(rdE), .rdM(rdM), .rdW(rdW),
      .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
      .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .McBusy(McBusy)
`ifdef HAZARD_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural model: remaining busy cycles as a plain integer countdown.
   int m_rem = 0;

   function automatic logic [1:0] m_fwd(input logic [REG_AW-1:0] rs);
      if (RegWriteM && rdM != 0 && rdM == rs) return 2'b10;
      if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [10:0] model();
      logic [1:0] fa, fb;
      logic sf, sd, se, fd, fe, fm, mb;
      {sf, sd, se, fd, fe, fm, mb} = '0;
      if (rst) return '0;
      fa = m_fwd(rs1E);
      fb = m_fwd(rs2E);
      if (m_rem > 0) begin
         {sf, sd, se, fm, mb} = 5'b11111;
      end else if (PCsrcE) begin
         fd = 1; fe = 1;
      end else if (McStartE && MC_LAT > 1) begin
         {sf, sd, se, fm} = 4'b1111;
      end else if (MemReadE && rdE != 0 && (rdE == rs1D || rdE == rs2D)) begin
         sf = 1; sd = 1; fe = 1;
      end
      return {fa, fb, sf, sd, se, fd, fe, fm, mb};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m_rem <= 0;
      else if (m_rem > 0) m_rem <= m_rem - 1;
      else if (McStartE && MC_LAT > 1) m_rem <= MC_LAT - 1;
   end

   task automatic clr_in();
      {PCsrcE, MemReadE, McStartE, RegWriteM, RegWriteW} = '0;
      {rdE, rdM, rdW, rs1D, rs2D, rs1E, rs2E} = '0;
   endtask

   task automatic test_reset();
      clr_in();
      rst = 1'b1;
      RegWriteM = 1; rdM = 5; rs1E = 5; MemReadE = 1; rdE = 3; rs1D = 3;
      #12;
      tests++;
      if (got !== 11'b0) begin fails++; $display("FAIL reset_outputs: got %b want %b", got, 11'b0); end
      @(negedge clk); rst = 1'b0; clr_in();
      #1;
      tests++;
      if (got !== 11'b0) begin fails++; $display("FAIL reset_release: got %b want %b", got, 11'b0); end
   endtask

   task automatic test_forward();
      @(negedge clk); clr_in();
      RegWriteM = 1; rdM = 5; RegWriteW = 1; rdW = 5; rs1E = 5; rs2E = 0;
      #1; tests++;
      if (got !== 11'b10000000000) begin fails++; $display("FAIL fwd_m_prio: got %b want %b", got, 11'b10000000000); end
      RegWriteM = 0;
      #1; tests++;
      if (got !== 11'b01000000000) begin fails++; $display("FAIL fwd_w: got %b want %b", got, 11'b01000000000); end
      RegWriteM = 1; rdM = 0; rs1E = 0; RegWriteW = 1; rdW = 9; rs2E = 9;
      #1; tests++;
      if (got !== 11'b00010000000) begin fails++; $display("FAIL fwd_x0: got %b want %b", got, 11'b00010000000); end
   endtask

   task automatic test_load_use();
      @(negedge clk); clr_in();
      MemReadE = 1; rdE = 7; rs2D = 7;
      #1; tests++;
      if (got !== 11'b00001100100) begin fails++; $display("FAIL load_use: got %b want %b", got, 11'b00001100100); end
      @(negedge clk); clr_in();
      #1; tests++;
      if (got !== 11'b0) begin fails++; $display("FAIL load_use_clear: got %b want %b", got, 11'b0); end
      @(negedge clk);
      MemReadE = 1; rdE = 7; rs2D = 7; PCsrcE = 1;
      #1; tests++;
      if (got !== 11'b00000001100) begin fails++; $display("FAIL branch_over_lu: got %b want %b", got, 11'b00000001100); end
      @(negedge clk); clr_in();
      MemReadE = 1; rdE = 0; rs1D = 0;
      #1; tests++;
      if (got !== 11'b0) begin fails++; $display("FAIL load_use_x0: got %b want %b", got, 11'b0); end
   endtask

   task automatic test_multicycle();
      @(negedge clk); clr_in();
      McStartE = 1;
      #1; tests++;
      if (got !== 11'b00001110010) begin fails++; $display("FAIL mc_start: got %b want %b", got, 11'b00001110010); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); clr_in();
         PCsrcE = (i == 1);
         #1; tests++;
         if (got !== 11'b00001110011) begin fails++; $display("FAIL mc_busy%0d: got %b want %b", i, got, 11'b00001110011); end
      end
      @(negedge clk); clr_in();
      #1; tests++;
      if (got !== 11'b0) begin fails++; $display("FAIL mc_done: got %b want %b", got, 11'b0); end
   endtask

   task automatic test_reset_mid_busy();
      @(negedge clk); clr_in(); McStartE = 1;
      @(negedge clk); clr_in();
      @(negedge clk);
      tests++;
      if (got !== 11'b00001110011) begin fails++; $display("FAIL pre_rst_busy: got %b want %b", got, 11'b00001110011); end
      #2; rst = 1'b1; RegWriteM = 1; rdM = 4; rs2E = 4;
      #1; tests++;
      if (got !== 11'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want %b", got, 11'b0); end
      @(negedge clk); rst = 1'b0; clr_in();
      for (int i = 0; i < 3; i++) begin
         #1; tests++;
         if (got !== 11'b0) begin fails++; $display("FAIL post_rst%0d: got %b want %b", i, got, 11'b0); end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         RegWriteM = $urandom_range(1, 0); RegWriteW = $urandom_range(1, 0);
         rdE = $urandom_range(3, 0); rdM = $urandom_range(3, 0); rdW = $urandom_range(3, 0);
         rs1D = $urandom_range(3, 0); rs2D = $urandom_range(3, 0);
         rs1E = $urandom_range(3, 0); rs2E = $urandom_range(3, 0);
         MemReadE = ($urandom_range(2, 0) == 0);
         PCsrcE = ($urandom_range(3, 0) == 0);
         McStartE = 0;
         if (m_rem == 0 && $urandom_range(7, 0) == 0) begin
            McStartE = 1; PCsrcE = 0; MemReadE = 0;
         end
         #1;
         exp_v = model();
         tests++;
         if (got !== exp_v) begin fails++; $display("FAIL random%0d: got %b want %b", n, got, exp_v); end
      end
      @(negedge clk); clr_in();
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf();
      @(negedge clk); clr_in(); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); clr_in(); MemReadE = 1; rdE = 6; rs1D = 6;
         @(negedge clk); clr_in();
      end
      @(negedge clk); McStartE = 1;
      for (int i = 0; i < 4; i++) begin @(negedge clk); clr_in(); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); PCsrcE = 1;
         @(negedge clk); clr_in();
      end
      #1; tests++;
      if (stall_cnt !== 32'd6) begin fails++; $display("FAIL stall_cnt: got %0d want 6", stall_cnt); end
      tests++;
      if (flush_cnt !== 32'd3) begin fails++; $display("FAIL flush_cnt: got %0d want 3", flush_cnt); end
   endtask
`endif

   initial begin
      clr_in();
      test_reset();
      test_forward();
      test_load_use();
      test_multicycle();
      test_reset_mid_busy();
      test_random();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised successor hazard unit for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Keeps M/W operand forwarding for the E stage.
- Adds load-use stall detection, branch flush of D and E, and a multi-cycle execute stall (MUL/DIV) driven by a counter FSM.
- Sits beside the datapath; drives the stage-register enables, the stage-register flushes and the E-stage forward muxes.

Parameters:
REG_AW, 5, register-address width (32 registers).
MC_LAT, 4, total E-stage occupancy in cycles of a multi-cycle op; must be >= 1. A value of 1 means no stall.
CNT_W, 3, multi-cycle counter width; must hold MC_LAT-1.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
PCsrcE  in  1  branch/jump taken, resolved in E
MemReadE  in  1  instruction in E is a load
McStartE  in  1  multi-cycle op enters E this cycle (1-cycle pulse)
RegWriteM  in  1  M-stage instruction writes rd
RegWriteW  in  1  W-stage instruction writes rd
rdE  in  REG_AW  E-stage destination register
rdM  in  REG_AW  M-stage destination register
rdW  in  REG_AW  W-stage destination register
rs1D  in  REG_AW  D-stage source 1
rs2D  in  REG_AW  D-stage source 2
rs1E  in  REG_AW  E-stage source 1
rs2E  in  REG_AW  E-stage source 2
ForwardAE  out  2  operand A select: 00 register file, 10 from M, 01 from W
ForwardBE  out  2  operand B select: same encoding as ForwardAE
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register
FlushM  out  1  clear EX/MEM register (inject bubble)
McBusy  out  1  multi-cycle stall in progress

Behaviour:
Reset:
- While rst=1, every output is 0, the FSM is in IDLE and the counter is 0. This applies asynchronously, including mid-stall.
- The first posedge after rst deasserts evaluates normally.

Forwarding (combinational):
- ForwardAE = 10 if RegWriteM & rdM!=0 & rdM==rs1E.
- Otherwise ForwardAE = 01 if RegWriteW & rdW!=0 & rdW==rs1E.
- Otherwise ForwardAE = 00.
- M has priority over W. ForwardBE is identical using rs2E.
- Register x0 is never forwarded.

Load-use (combinational, IDLE only):
- lu = MemReadE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
- When lu=1: StallF=1, StallD=1, FlushE=1 (one bubble).
- Self-clears the next cycle, once the load has moved to M.

Branch (combinational, IDLE only):
- When PCsrcE=1: FlushD=1, FlushE=1, StallF=0, StallD=0.
- Branch overrides load-use, because the stalled D instruction is squashed anyway.
- Flushes are asserted in the same cycle as PCsrcE, with no half-cycle behaviour.

Multi-cycle FSM, states IDLE and BUSY:
- IDLE -> BUSY on posedge when McStartE=1 and MC_LAT>1; counter <= MC_LAT-1.
- BUSY: counter decrements each posedge; BUSY -> IDLE on the posedge where the counter goes 1 -> 0.
- BUSY outputs: McBusy=1, StallF=1, StallD=1, StallE=1, FlushM=1. FlushD, FlushE and the load-use/branch outputs are all 0.
- Total stall is MC_LAT-1 cycles. The op leaves E on the first IDLE cycle.
- In the McStartE cycle itself (still IDLE), StallF, StallD, StallE and FlushM are already 1.
- McStartE while BUSY is ignored (illegal by construction).
- PCsrcE while BUSY is ignored; busy has priority.
- With MC_LAT=1, McStartE has no effect.
- Forwarding outputs are unaffected by the FSM state.

Optional Feature:
HAZARD_PERF_EN:
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0].
- stall_cnt increments every cycle StallF=1.
- flush_cnt increments every cycle PCsrcE causes FlushD.
- Both counters wrap at 2^32 and are cleared by rst.
- When not defined, these ports and registers do not exist and all other behaviour is identical.

Test Plan:
- RegWriteM=1, rdM=5, RegWriteW=1, rdW=5, rs1E=5, rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01.
- rdM=0, RegWriteM=1, rs1E=0 -> ForwardAE=00 (x0 never forwarded).
- MemReadE=1, rdE=7, rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Add PCsrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
- MC_LAT=4, McStartE pulse -> StallF/StallD/StallE/FlushM=1 for the start cycle plus 3 BUSY cycles, McBusy=1 for 3 cycles, then all 0. A PCsrcE pulse during BUSY has no effect.
- Assert rst mid-BUSY (counter=2) -> all outputs 0 immediately. After release, McBusy stays 0 with no further stall.
- With HAZARD_PERF_EN defined: 2 load-use stalls plus one MC_LAT=4 op -> stall_cnt=6. 3 branches -> flush_cnt=3.
